// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   function automatic logic is_shift(input logic [7:0] code);
      return (code == SC_LSHIFT) || (code == SC_RSHIFT);
   endfunction

endpackage

// File: rtl/ps2_scancode_lut.sv
// Set-2 make code to ASCII: letters, digits, space, enter, backspace; 0 means "no key".
module ps2_scancode_lut (
   input  logic [7:0] scan,
   input  logic       shift,
   output logic [7:0] ascii
);

   logic [7:0] base;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      base = 8'h00;
      case (scan)
         8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;  8'h23: base = 8'h64;
         8'h24: base = 8'h65;  8'h2B: base = 8'h66;  8'h34: base = 8'h67;  8'h33: base = 8'h68;
         8'h43: base = 8'h69;  8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
         8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;  8'h4D: base = 8'h70;
         8'h15: base = 8'h71;  8'h2D: base = 8'h72;  8'h1B: base = 8'h73;  8'h2C: base = 8'h74;
         8'h3C: base = 8'h75;  8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
         8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
         8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1E: base = 8'h32;  8'h26: base = 8'h33;
         8'h25: base = 8'h34;  8'h2E: base = 8'h35;  8'h36: base = 8'h36;  8'h3D: base = 8'h37;
         8'h3E: base = 8'h38;  8'h46: base = 8'h39;
         8'h29: base = 8'h20;  8'h5A: base = 8'h0D;  8'h66: base = 8'h08;
         default: base = 8'h00;
      endcase
      ascii = base;
      // Shift only affects letters; upper case sits 0x20 below lower case.
      if (shift && (base >= 8'h61) && (base <= 8'h7A))
         ascii = base - 8'h20;
   end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver, Set-2 decoder and key FIFO read by the memory subsystem.
module ps2_keyboard
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       CLK_CPU,
   input  logic       RST,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       clean_key_buffer,
   output logic [7:0] pressed_key,
   output logic       key_valid,
   output logic       frame_err,
   output logic       key_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0] clk_sync, data_sync;
   logic       clk_prev, fall, rx_bit;

   // Synchronizers reset to the idle-high line level so reset never fakes a fall.
   // NOTE: sequential state always uses non-blocking assignments.
   always_ff @(posedge CLK_CPU) begin
      if (RST) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
      end
   end

   assign fall   = clk_prev & ~clk_sync[1];
   assign rx_bit = data_sync[1];

   rx_state_t       state, state_nx;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            par_bit, byte_valid, byte_nx, err_nx, timeout;
   logic [TO_W-1:0] to_cnt;

   assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

   always_comb begin
      state_nx = state;
      byte_nx  = 1'b0;
      err_nx   = 1'b0;
      if (timeout) begin
         state_nx = IDLE;
         err_nx   = 1'b1;
      end else if (fall) begin
         unique case (state)
            IDLE:   if (rx_bit) err_nx = 1'b1; else state_nx = DATA;
            DATA:   if (bit_cnt == 3'd7) state_nx = PARITY;
            PARITY: state_nx = STOP;
            STOP: begin
               state_nx = IDLE;
               if (rx_bit && ^{shreg, par_bit}) byte_nx = 1'b1;
               else                             err_nx  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge CLK_CPU) begin
      if (RST) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         par_bit    <= 1'b0;
         to_cnt     <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         byte_valid <= byte_nx;
         frame_err  <= err_nx;
         if (fall || state == IDLE) to_cnt <= '0;
         else if (!timeout)         to_cnt <= to_cnt + TO_W'(1);
         if (fall) begin
            case (state)
               IDLE:    bit_cnt <= 3'd0;
               DATA: begin
                  shreg   <= {rx_bit, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY:  par_bit <= rx_bit;
               default: ;
            endcase
         end
      end
   end

   logic       shift_q, brk_q, ext_q, push_req;
   logic [7:0] push_data, lut_ascii;

   ps2_scancode_lut u_lut (
      .scan  (shreg),
      .shift (shift_q),
      .ascii (lut_ascii)
   );

   always_ff @(posedge CLK_CPU) begin
      if (RST) begin
         shift_q   <= 1'b0;
         brk_q     <= 1'b0;
         ext_q     <= 1'b0;
         push_req  <= 1'b0;
         push_data <= 8'h00;
      end else begin
         push_req <= 1'b0;
         if (byte_valid) begin
            if (shreg == SC_BREAK)    brk_q <= 1'b1;
            else if (shreg == SC_EXT) ext_q <= 1'b1;
            else if (brk_q) begin
               if (is_shift(shreg)) shift_q <= 1'b0;
               brk_q <= 1'b0;
               ext_q <= 1'b0;
            end else if (ext_q)       ext_q <= 1'b0;
            else if (is_shift(shreg)) shift_q <= 1'b1;
            else if (lut_ascii != 8'h00) begin
               push_req  <= 1'b1;
               push_data <= lut_ascii;
            end
         end
      end
   end

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W:0]   count;
   logic             empty, full, do_pop, do_push;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
   assign do_pop  = clean_key_buffer && !empty;
   assign do_push = push_req && (!full || do_pop);

   // NOTE: storage is not reset; count/pointers alone define which entries are valid.
   always_ff @(posedge CLK_CPU) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge CLK_CPU) begin
      if (RST) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         key_overflow <= 1'b0;
      end else begin
         key_overflow <= push_req && full && !do_pop;
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: ;
         endcase
      end
   end

   assign key_valid   = !empty;
   assign pressed_key = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 keyboard receiver and key buffer: the producer side of the keyboard interface read by the memory subsystem at address 0xFFFFFFFF.
- Receives PS/2 device-to-host frames and decodes Set-2 scan codes (make/break, shift) into ASCII.
- Queues keys in a small FIFO and presents the head on pressed_key; pops one entry per cycle that clean_key_buffer is high.
- Lives in the top level next to the video memory, clocked by CLK_CPU.

Parameters:
FIFO_DEPTH, 8, key buffer entries (power of 2, >=2)
TIMEOUT_CYCLES, 50000, CLK_CPU cycles without a ps2_clk fall before a partial frame is aborted

Ports:
CLK_CPU  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
clean_key_buffer  input  1  pop request from memory subsystem, one entry per high cycle
pressed_key  output  8  ASCII of FIFO head; 8'h00 when FIFO empty
key_valid  output  1  FIFO non-empty
frame_err  output  1  one-cycle pulse: frame discarded (bad start, parity, stop or timeout)
key_overflow  output  1  one-cycle pulse: decoded key dropped because FIFO full

Behaviour:
- Reset: all outputs 0; FIFO empty; shift, break and extended flags cleared; receiver in IDLE. Reset mid-frame abandons the frame with no error pulse.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchronizer. A fall is a synced ps2_clk 1->0 transition, detected in cycle N. ps2_data is sampled in that same cycle.
- Receiver FSM (advances only on a fall):
  - IDLE: data=0 -> DATA, bit_cnt=0. data=1 -> stay in IDLE and pulse frame_err.
  - DATA: shift data in LSB first. After 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: the frame is good if data=1 and the 8 data bits plus the parity bit have an odd count of 1s. Good frame: byte_valid in cycle N+1. Bad frame: frame_err in cycle N+1. Either way -> IDLE.
- Timeout: a counter clears on every fall. In any state other than IDLE, reaching TIMEOUT_CYCLES -> IDLE with a frame_err pulse.
- Decoder, on byte_valid with byte b:
  - b=F0: set brk. b=E0: set ext. No push.
  - Any other b with brk=1: if b is 12/59, clear shift. Then clear brk and ext. No push.
  - Any other b with ext=1: extended keys are dropped. Clear ext. No push.
  - Otherwise: if b is 12/59, set shift and do not push. Else look up ascii = lut(b, shift). If ascii != 0, push.
- Push timing: the push commits in cycle N+2. pressed_key and key_valid reflect a push into an empty FIFO from cycle N+3.
- FIFO:
  - pressed_key is combinational from the head register and is forced to 0 when empty.
  - Pop when clean_key_buffer=1 and not empty. A pop on empty is ignored.
  - Push and pop in the same cycle both take effect; count is unchanged.
  - Push when full and no pop: the key is dropped and key_overflow pulses. Push when full with a simultaneous pop is accepted.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- Character code 0 is reserved for "no key"; the LUT never maps a key to 0.

Decomposition:
- Package ps2_pkg holds:
  - rx_state_t enum (IDLE, DATA, PARITY, STOP)
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59
- One sub-module, ps2_scancode_lut: combinational, inputs {scan[7:0], shift}, output ascii[7:0].
  - Covers letters, digits, space (29->20), enter (5A->0D), backspace (66->08).
  - Unmapped codes -> 0.
- The receiver FSM, decoder and FIFO stay in ps2_keyboard.

Test Plan:
- Frame 0x1C, odd parity 0 -> key_valid=1, pressed_key=8'h61. Then clean_key_buffer high one cycle -> pressed_key=8'h00, key_valid=0.
- Frames 12,1C,F0,1C,F0,12,1C -> FIFO holds 8'h41 then 8'h61. No entries from the break codes.
- Frame 0x1C with parity bit 1 -> frame_err pulses once, FIFO stays empty. A following good 0x32 frame -> pressed_key=8'h62.
- 9 make codes (1C x9) with no pops -> 8 entries of 8'h61 retained, key_overflow pulses once. 8 pops -> empty.
- Start bit plus 4 data bits, then idle TIMEOUT_CYCLES -> frame_err pulses, FSM in IDLE. Next full frame 0x1C is decoded correctly.
- FIFO full, push completes in the same cycle clean_key_buffer=1 -> no overflow, count stays 8, new key at tail. RST asserted mid-frame -> all outputs 0 next cycle.
